// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate_pipe slice: pre-op encodings and the
// per-beat control word that travels down the pipeline with its data.
package rotate_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_XOR  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    // Sized for the widest supported data path (64 bits -> 6 amount bits).
    localparam int K_MAX_W = 6;

    typedef struct packed {
        logic               right;
        logic               shift;
        logic [K_MAX_W-1:0] k;
    } beat_ctrl_t;

endpackage

// File: rtl/rotate_stage.sv
// One barrel level: moves the word by 2^LEVEL positions when k[LEVEL] is set,
// then registers data, control and valid under the global advance.
module rotate_stage
    import rotate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    input  beat_ctrl_t       ctrl_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output beat_ctrl_t       ctrl_o,
    output logic [WIDTH-1:0] mux_o
);

    localparam int AMT = 1 << LEVEL;

    logic [WIDTH-1:0] data_d;
    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    beat_ctrl_t       ctrl_q;

    // Wrapped-in bits are dropped for logical shifts, giving zero fill.
    always_comb begin
        data_d = data_i;
        if (ctrl_i.k[LEVEL]) begin
            if (ctrl_i.right) begin
                data_d = (data_i >> AMT) | (ctrl_i.shift ? '0 : (data_i << (WIDTH - AMT)));
            end else begin
                data_d = (data_i << AMT) | (ctrl_i.shift ? '0 : (data_i >> (WIDTH - AMT)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            ctrl_q <= '0;
        end else if (adv) begin
            vld_q  <= vld_i;
            data_q <= data_d;
            ctrl_q <= ctrl_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign ctrl_o = ctrl_q;
    assign mux_o  = data_d;

endmodule

// File: rtl/rotate_pipe.sv
// Pipelined pre-op + rotate/logical-shift unit, SHW+1 cycles latency, global stall.
// Optional zero flag on the result when ROTATE_PIPE_FLAGS_EN is defined.
module rotate_pipe
    import rotate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   k,
    input  logic             right,
    input  logic             shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f
`ifdef ROTATE_PIPE_FLAGS_EN
    ,
    output logic             f_zero
`endif
);

    logic             adv;
    logic [WIDTH-1:0] pre_d;
    beat_ctrl_t       ctrl_d;

    logic             vld0_q;
    logic [WIDTH-1:0] data0_q;
    beat_ctrl_t       ctrl0_q;

    logic             vld_s  [0:SHW];
    logic [WIDTH-1:0] data_s [0:SHW];
    beat_ctrl_t       ctrl_s [0:SHW];
    logic [WIDTH-1:0] mux_s  [1:SHW];

    assign out_valid = vld_s[SHW];
    assign in_ready  = !out_valid || out_ready;
    assign adv       = in_ready;

    always_comb begin
        case (op)
            OP_XOR:  pre_d = a ^ b;
            OP_AND:  pre_d = a & b;
            OP_OR:   pre_d = a | b;
            default: pre_d = a;
        endcase
        ctrl_d            = '0;
        ctrl_d.right      = right;
        ctrl_d.shift      = shift;
        ctrl_d.k[SHW-1:0] = k;
    end

    // Stage 0: capture the pre-op result and the beat's controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_q  <= 1'b0;
            data0_q <= '0;
            ctrl0_q <= '0;
        end else if (adv) begin
            vld0_q  <= in_valid;
            data0_q <= pre_d;
            ctrl0_q <= ctrl_d;
        end
    end

    assign vld_s[0]  = vld0_q;
    assign data_s[0] = data0_q;
    assign ctrl_s[0] = ctrl0_q;

    // Largest move first: stage i handles amount bit SHW-i.
    for (genvar i = 1; i <= SHW; i++) begin : g_stage
        rotate_stage #(
            .WIDTH (WIDTH),
            .LEVEL (SHW - i)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv    (adv),
            .vld_i  (vld_s[i-1]),
            .data_i (data_s[i-1]),
            .ctrl_i (ctrl_s[i-1]),
            .vld_o  (vld_s[i]),
            .data_o (data_s[i]),
            .ctrl_o (ctrl_s[i]),
            .mux_o  (mux_s[i])
        );
    end

    assign f = data_s[SHW];

`ifdef ROTATE_PIPE_FLAGS_EN
    logic f_zero_q;
    logic unused_tail;

    // Flag is taken from the same value the last stage registers, so it lines up with f.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_zero_q <= 1'b0;
        end else if (adv) begin
            f_zero_q <= (mux_s[SHW] == '0);
        end
    end

    assign f_zero      = f_zero_q;
    assign unused_tail = ^ctrl_s[SHW];
`else
    logic unused_tail;
    assign unused_tail = ^{ctrl_s[SHW], mux_s[SHW]};
`endif

endmodule
